simt_regfile: RTL and testbench

- Per-core register file holding one register set for each of THREADS thread lanes, replacing per-thread register instances.
- Generalised in data width, register count and thread count.
- Adds a per-lane active mask, a latched block dimension, and a sequenced bulk-clear engine used between block dispatches.
- Sits between the decoder/scheduler and the per-lane ALU/LSU. Reads and writes are qualified by core_state.

---
 rtl/simt_regfile_pkg.sv | 17 +
 rtl/simt_regfile_if.sv | 29 ++
 rtl/simt_regfile_lane.sv | 72 +++++++
 rtl/simt_regfile.sv | 89 ++++++++
 tb/tb_simt_regfile.sv | 136 +++++++++++++
 5 files changed

// File: rtl/simt_regfile_pkg.sv
// simt_regfile_pkg: shared core-state encoding, write-source selects and clear FSM states
package simt_regfile_pkg;
   typedef enum logic [2:0] {
      CORE_IDLE    = 3'd0,
      CORE_FETCH   = 3'd1,
      CORE_DECODE  = 3'd2,
      CORE_REQUEST = 3'd3,
      CORE_WAIT    = 3'd4,
      CORE_EXECUTE = 3'd5,
      CORE_UPDATE  = 3'd6,
      CORE_DONE    = 3'd7
   } core_state_t;
   localparam logic [1:0] ARITHMETIC = 2'b00;
   localparam logic [1:0] MEMORY     = 2'b01;
   localparam logic [1:0] CONSTANT   = 2'b10;
   typedef enum logic {CLR_IDLE, CLR_RUN} clr_state_t;
endpackage

// File: rtl/simt_regfile_if.sv
// simt_regfile_if: scheduler/decoder/ALU/LSU side bus of the SIMT register file
interface simt_regfile_if #(parameter int THREADS = 4, parameter int DATA_BITS = 8, parameter int NUM_REGS = 16);
   import simt_regfile_pkg::*;
   localparam int ADDR_BITS = $clog2(NUM_REGS);
   logic [THREADS-1:0]           thread_mask;
   core_state_t                  core_state;
   logic [7:0]                   block_id;
   logic [7:0]                   block_dim;
   logic [ADDR_BITS-1:0]         decoded_rd_address;
   logic [ADDR_BITS-1:0]         decoded_rs_address;
   logic [ADDR_BITS-1:0]         decoded_rt_address;
   logic                         decoded_reg_write_enable;
   logic [1:0]                   decoded_reg_input_mux;
   logic [DATA_BITS-1:0]         decoded_immediate;
   logic [THREADS*DATA_BITS-1:0] alu_out;
   logic [THREADS*DATA_BITS-1:0] lsu_out;
   logic                         clear_start;
   logic                         clear_busy;
   logic [THREADS*DATA_BITS-1:0] rs;
   logic [THREADS*DATA_BITS-1:0] rt;
   modport master (output thread_mask, core_state, block_id, block_dim, decoded_rd_address,
                   decoded_rs_address, decoded_rt_address, decoded_reg_write_enable,
                   decoded_reg_input_mux, decoded_immediate, alu_out, lsu_out, clear_start,
                   input clear_busy, rs, rt);
   modport slave (input thread_mask, core_state, block_id, block_dim, decoded_rd_address,
                  decoded_rs_address, decoded_rt_address, decoded_reg_write_enable,
                  decoded_reg_input_mux, decoded_immediate, alu_out, lsu_out, clear_start,
                  output clear_busy, rs, rt);
endinterface

// File: rtl/simt_regfile_lane.sv
// simt_regfile_lane: one lane's free registers, specials and registered rs/rt read ports
module simt_regfile_lane
   import simt_regfile_pkg::*;
#(
   parameter int DATA_BITS = 8,
   parameter int NUM_REGS  = 16,
   parameter int THREADS   = 4,
   parameter int LANE      = 0,
   localparam int ADDR_BITS = $clog2(NUM_REGS)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 i_en,
   input  core_state_t          i_core_state,
   input  logic [7:0]           i_block_id,
   input  logic [7:0]           i_block_dim,
   input  logic [ADDR_BITS-1:0] i_rs_addr,
   input  logic [ADDR_BITS-1:0] i_rt_addr,
   input  logic                 i_clr,
   input  logic [ADDR_BITS-1:0] i_clr_addr,
   input  logic                 i_wr,
   input  logic [ADDR_BITS-1:0] i_wr_addr,
   input  logic [1:0]           i_mux,
   input  logic [DATA_BITS-1:0] i_imm,
   input  logic [DATA_BITS-1:0] i_alu,
   input  logic [DATA_BITS-1:0] i_lsu,
   output logic [DATA_BITS-1:0] o_rs,
   output logic [DATA_BITS-1:0] o_rt
);
   logic [DATA_BITS-1:0] r_regs [NUM_REGS-3];
   logic [DATA_BITS-1:0] r_bidx, r_bdim, r_rs, r_rt;
   logic [DATA_BITS-1:0] w_view [2**ADDR_BITS];
   logic [DATA_BITS-1:0] w_data;
   // Full address-space view; addresses past the specials read as zero
   for (genvar g = 0; g < 2**ADDR_BITS; g++) begin : g_view
      if (g < NUM_REGS-3) begin : g_free
         assign w_view[g] = r_regs[g];
      end else if (g == NUM_REGS-3) begin : g_bidx
         assign w_view[g] = r_bidx;
      end else if (g == NUM_REGS-2) begin : g_bdim
         assign w_view[g] = r_bdim;
      end else if (g == NUM_REGS-1) begin : g_tidx
         assign w_view[g] = DATA_BITS'(LANE);
      end else begin : g_none
         assign w_view[g] = '0;
      end
   end
   assign w_data = i_mux == MEMORY ? i_lsu : i_mux == CONSTANT ? i_imm : i_alu;
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS-3; i++) r_regs[i] <= '0;
         r_bidx <= '0;
         r_bdim <= DATA_BITS'(THREADS);
         r_rs   <= '0;
         r_rt   <= '0;
      end else if (i_clr) begin
         r_regs[i_clr_addr] <= '0;
      end else if (i_en) begin
         if (i_core_state == CORE_IDLE) begin
            r_bidx <= DATA_BITS'(i_block_id);
            r_bdim <= DATA_BITS'(i_block_dim);
         end
         if (i_core_state == CORE_REQUEST) begin
            r_rs <= w_view[i_rs_addr];
            r_rt <= w_view[i_rt_addr];
         end
         if (i_wr) r_regs[i_wr_addr] <= w_data;
      end
   end
   assign o_rs = r_rs;
   assign o_rt = r_rt;
endmodule

// File: rtl/simt_regfile.sv
// simt_regfile: per-core SIMT register file with latched decode and sequenced bulk clear
// Option: define SIMT_REGFILE_ZERO_REG_EN to make R0 a hardwired zero register.
module simt_regfile
   import simt_regfile_pkg::*;
#(
   parameter int THREADS   = 4,
   parameter int DATA_BITS = 8,
   parameter int NUM_REGS  = 16
) (
   input logic           clk,
   input logic           reset,
   simt_regfile_if.slave bus
);
   localparam int ADDR_BITS = $clog2(NUM_REGS);
   clr_state_t                   r_state;
   logic [ADDR_BITS-1:0]         r_cnt, r_rd;
   logic [1:0]                   r_mux;
   logic [DATA_BITS-1:0]         r_imm;
   logic                         r_we, r_busy;
   logic                         w_rd_ok, w_wr;
   logic [THREADS*DATA_BITS-1:0] w_rs, w_rt;
`ifdef SIMT_REGFILE_ZERO_REG_EN
   assign w_rd_ok = r_rd != '0 && r_rd < ADDR_BITS'(NUM_REGS-3);
`else
   assign w_rd_ok = r_rd < ADDR_BITS'(NUM_REGS-3);
`endif
   assign w_wr = r_state == CLR_IDLE && bus.core_state == CORE_UPDATE && r_we && w_rd_ok && r_mux != 2'b11;
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= CLR_IDLE;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_rd    <= '0;
         r_mux   <= '0;
         r_imm   <= '0;
         r_we    <= 1'b0;
      end else begin
         case (r_state)
            CLR_IDLE: begin
               if (bus.clear_start) begin
                  r_state <= CLR_RUN;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
               end
               if (bus.core_state == CORE_REQUEST && |bus.thread_mask) begin
                  r_rd  <= bus.decoded_rd_address;
                  r_mux <= bus.decoded_reg_input_mux;
                  r_imm <= bus.decoded_immediate;
                  r_we  <= bus.decoded_reg_write_enable;
               end
            end
            CLR_RUN: begin
               if (r_cnt == ADDR_BITS'(NUM_REGS-4)) begin
                  r_state <= CLR_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: r_state <= CLR_IDLE;
         endcase
      end
   end
   for (genvar t = 0; t < THREADS; t++) begin : g_lane
      simt_regfile_lane #(.DATA_BITS(DATA_BITS), .NUM_REGS(NUM_REGS), .THREADS(THREADS), .LANE(t)) u_lane (
         .clk          (clk),
         .reset        (reset),
         .i_en         (bus.thread_mask[t]),
         .i_core_state (bus.core_state),
         .i_block_id   (bus.block_id),
         .i_block_dim  (bus.block_dim),
         .i_rs_addr    (bus.decoded_rs_address),
         .i_rt_addr    (bus.decoded_rt_address),
         .i_clr        (r_busy),
         .i_clr_addr   (r_cnt),
         .i_wr         (w_wr),
         .i_wr_addr    (r_rd),
         .i_mux        (r_mux),
         .i_imm        (r_imm),
         .i_alu        (bus.alu_out[t*DATA_BITS +: DATA_BITS]),
         .i_lsu        (bus.lsu_out[t*DATA_BITS +: DATA_BITS]),
         .o_rs         (w_rs[t*DATA_BITS +: DATA_BITS]),
         .o_rt         (w_rt[t*DATA_BITS +: DATA_BITS])
      );
   end
   assign bus.rs         = w_rs;
   assign bus.rt         = w_rt;
   assign bus.clear_busy = r_busy;
endmodule

// File: tb/tb_simt_regfile.sv
// tb_simt_regfile: directed checks of reads, specials, masked writes and bulk clear
module tb_simt_regfile;
   import simt_regfile_pkg::*;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;
   int   n;
   simt_regfile_if #(.THREADS(4), .DATA_BITS(8), .NUM_REGS(16)) bus ();
   simt_regfile #(.THREADS(4), .DATA_BITS(8), .NUM_REGS(16)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   task automatic cyc(input core_state_t s);
      bus.core_state = s;
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic rd2(input logic [3:0] a, input logic [3:0] b);
      bus.decoded_reg_write_enable = 1'b0;
      bus.decoded_rs_address = a;
      bus.decoded_rt_address = b;
      cyc(CORE_REQUEST);
   endtask
   task automatic wr(input logic [3:0] rd, input logic [1:0] mux, input logic [7:0] imm);
      bus.decoded_rd_address = rd;
      bus.decoded_reg_input_mux = mux;
      bus.decoded_immediate = imm;
      bus.decoded_reg_write_enable = 1'b1;
      cyc(CORE_REQUEST);
      cyc(CORE_UPDATE);
      bus.decoded_reg_write_enable = 1'b0;
   endtask
   initial begin
      bus.thread_mask = 4'b1111;
      bus.core_state = CORE_WAIT;
      bus.block_id = '0;
      bus.block_dim = '0;
      bus.decoded_rd_address = '0;
      bus.decoded_rs_address = '0;
      bus.decoded_rt_address = '0;
      bus.decoded_reg_write_enable = 1'b0;
      bus.decoded_reg_input_mux = '0;
      bus.decoded_immediate = '0;
      bus.alu_out = '0;
      bus.lsu_out = '0;
      bus.clear_start = 1'b0;
      cyc(CORE_WAIT);
      cyc(CORE_WAIT);
      chk("reset_rs", bus.rs, 32'h0);
      chk("reset_rt", bus.rt, 32'h0);
      chk("reset_busy", {31'b0, bus.clear_busy}, 32'h0);
      reset = 1'b0;
      rd2(4'd15, 4'd14);
      chk("tidx", bus.rs, 32'h03020100);
      chk("bdim_reset", bus.rt, 32'h04040404);
      bus.block_id = 8'h25;
      bus.block_dim = 8'd3;
      cyc(CORE_IDLE);
      rd2(4'd13, 4'd14);
      chk("bidx", bus.rs, 32'h25252525);
      chk("bdim", bus.rt, 32'h03030303);
      bus.thread_mask = 4'b1011;
      wr(4'd2, CONSTANT, 8'h5A);
      bus.thread_mask = 4'b1111;
      rd2(4'd2, 4'd15);
      chk("mask_const", bus.rs, 32'h5A005A5A);
      chk("mask_tidx", bus.rt, 32'h03020100);
      bus.alu_out = 32'h40302010;
      wr(4'd13, ARITHMETIC, 8'h00);
      wr(4'd4, ARITHMETIC, 8'h00);
      rd2(4'd13, 4'd4);
      chk("special_drop", bus.rs, 32'h25252525);
      chk("alu_write", bus.rt, 32'h40302010);
      bus.lsu_out = 32'hA1B2C3D4;
      wr(4'd5, MEMORY, 8'h00);
      wr(4'd4, 2'b11, 8'hEE);
      rd2(4'd4, 4'd5);
      chk("mux11_drop", bus.rs, 32'h40302010);
      chk("lsu_write", bus.rt, 32'hA1B2C3D4);
      for (int r = 0; r < 13; r++) wr(4'(r), CONSTANT, 8'(8'h80 + r));
      rd2(4'd12, 4'd7);
      chk("fill_r12", bus.rs, 32'h8C8C8C8C);
      chk("fill_r7", bus.rt, 32'h87878787);
      bus.clear_start = 1'b1;
      cyc(CORE_WAIT);
      bus.clear_start = 1'b0;
      bus.decoded_rs_address = 4'd1;
      bus.decoded_rt_address = 4'd1;
      n = 0;
      while (bus.clear_busy && n < 30) begin
         n++;
         bus.clear_start = (n == 5);
         cyc(n == 3 ? CORE_REQUEST : CORE_WAIT);
      end
      bus.clear_start = 1'b0;
      chk("busy_cycles", n, 32'd13);
      chk("busy_rs_hold", bus.rs, 32'h8C8C8C8C);
      chk("busy_rt_hold", bus.rt, 32'h87878787);
      rd2(4'd0, 4'd12);
      chk("clr_r0", bus.rs, 32'h0);
      chk("clr_r12", bus.rt, 32'h0);
      rd2(4'd7, 4'd13);
      chk("clr_r7", bus.rs, 32'h0);
      chk("clr_bidx", bus.rt, 32'h25252525);
      rd2(4'd14, 4'd15);
      chk("clr_bdim", bus.rs, 32'h03030303);
      chk("clr_tidx", bus.rt, 32'h03020100);
      bus.clear_start = 1'b1;
      cyc(CORE_WAIT);
      bus.clear_start = 1'b0;
      chk("busy_start", {31'b0, bus.clear_busy}, 32'h1);
      repeat (4) cyc(CORE_WAIT);
      reset = 1'b1;
      cyc(CORE_WAIT);
      chk("reset_mid_clear", {31'b0, bus.clear_busy}, 32'h0);
      reset = 1'b0;
      rd2(4'd13, 4'd14);
      chk("reset_bidx", bus.rs, 32'h0);
      chk("reset_bdim", bus.rt, 32'h04040404);
      wr(4'd0, CONSTANT, 8'hFF);
      rd2(4'd0, 4'd15);
`ifdef SIMT_REGFILE_ZERO_REG_EN
      chk("zero_reg", bus.rs, 32'h0);
`else
      chk("r0_plain", bus.rs, 32'hFFFFFFFF);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
